seq_arith_unit: RTL and testbench
=================================

// Module: seq_arith_unit
// PURPOSE
//   Parametrised, FSM-sequenced arithmetic datapath: computes (A + B - C) << N
//   (mode 0) or (A - B + C) << N (mode 1) on one shared adder/subtractor and accumulator.
//   Generalises the fixed 8-bit, fixed x2 path with a start/done handshake,
//   programmable shift count and signed-overflow detection.
//   Sits between operand registers and downstream consumers sampling result on done.
// PARAMETERS
//   WIDTH  8  datapath width in bits for A, B, C, result and accumulator
//   SHW    3  width of shamt; maximum shift count is 2**SHW-1
// PORTS
//   CLK     in   1      clock; all state changes on posedge
//   Clr     in   1      asynchronous, active-low reset
//   start   in   1      request; sampled only in IDLE
//   mode    in   1      0: A+B-C, 1: A-B+C; captured with start
//   shamt   in   SHW    left-shift count N; captured with start
//   A,B,C   in   WIDTH  operands, two's complement; captured with start
//   busy    out  1      1 in every state except IDLE
//   done    out  1      1 for exactly one cycle (state DONE)
//   result  out  WIDTH  accumulator T; valid when done=1
//   ovf     out  1      sticky signed overflow for the current operation
// BEHAVIOUR
//   Clocking and reset: one clock (CLK); reset Clr is asynchronous and active-low.
//     Clr=0 forces IDLE, T=0, shift count=0, busy=0, done=0, ovf=0, captured operands=0.
//     Holds regardless of CLK. Reset mid-operation aborts with no done pulse.
//   FSM states: IDLE -> ADD1 -> ADD2 -> SHIFT (0..N cycles) -> DONE -> IDLE.
//     IDLE:  start=1 at posedge: capture A,B,C,mode,shamt; clear ovf; go to ADD1.
//            start=0: remain in IDLE; T and ovf hold.
//     ADD1:  T <= Acap + Bcap (mode 0) or Acap - Bcap (mode 1); go to ADD2.
//     ADD2:  T <= T - Ccap (mode 0) or T + Ccap (mode 1).
//            Go to SHIFT if shamt!=0, else to DONE.
//     SHIFT: T <= {T[WIDTH-2:0],1'b0}; cnt <= cnt+1.
//            Go to DONE when cnt==shamt-1 (exactly shamt shift cycles); cnt cleared on exit.
//     DONE:  done=1; T holds; go to IDLE unconditionally.
//   Latency: start edge = edge 0; done is high from edge 3+N to edge 4+N.
//   start while busy=1 is ignored: no capture, no restart.
//   start high in DONE is also ignored. A new start is accepted in IDLE the cycle after DONE.
//   Arithmetic: modulo 2**WIDTH, with no saturation.
//   ovf is set (sticky) on signed overflow in any step:
//     - add: operands have the same sign and the sum sign differs;
//     - subtract: operands have different signs and the result sign differs from the minuend;
//     - shift: T[WIDTH-1] != T[WIDTH-2] before the shift.
//   result = T at all times. It is stable from DONE until the ADD1 edge of the next operation.
//   Outputs busy and done are decoded from registered state, with no combinational path from inputs.
// TESTING (WIDTH=8, SHW=3)
//   - Base case: A=2, B=4, C=3, mode=0, N=1 -> done at edge 4, result=6, ovf=0.
//     Same operands with mode=1 -> result=2.
//   - N=0: A=5, B=1, C=3, mode=0 -> done at edge 3, result=3; N=7 with A=1, B=0, C=0 -> result=0x80, ovf=1.
//   - Add overflow: A=100, B=100, C=0, mode=0, N=0 -> result=0xC8, ovf=1.
//     The next op A=1, B=1, C=0 -> ovf=0, result=2.
//   - Start while busy: pulse start with A=9 during SHIFT -> ignored. The first result is unchanged.
//     Exactly one done pulse, and busy stays high through it.
//   - Reset mid-op: Clr=0 during ADD2 -> immediately busy=0, done=0, result=0, ovf=0.
//     After Clr=1 the FSM stays in IDLE until start.
//   - Back-to-back: start held high continuously -> one operation per 4+N cycles.
//     done pulses are separated by exactly one IDLE cycle.

Source files
------------

// File: rtl/seq_arith_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_arith_unit : FSM-sequenced (A +/- B -/+ C) << N on one shared adder
// Revision 1.0
// ---------------------------------------------------------------------------
module seq_arith_unit #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             CLK,
  input  logic             Clr,
  input  logic             start,
  input  logic             mode,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int c_msb = WIDTH - 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADD1  = 3'd1,
    ST_ADD2  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic             mode_q, mode_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] w_op_x, w_op_y, w_sum;
  logic             w_do_sub, w_add_ovf;

  // ADD1 works on the captured A/B, ADD2 folds C into the accumulator
  always_comb begin
    w_op_x   = (state_q == ST_ADD1) ? a_q : t_q;
    w_op_y   = (state_q == ST_ADD1) ? b_q : c_q;
    w_do_sub = (state_q == ST_ADD1) ? mode_q : ~mode_q;
    w_sum    = w_do_sub ? (w_op_x - w_op_y) : (w_op_x + w_op_y);
    if (w_do_sub)
      w_add_ovf = (w_op_x[c_msb] != w_op_y[c_msb]) && (w_sum[c_msb] != w_op_x[c_msb]);
    else
      w_add_ovf = (w_op_x[c_msb] == w_op_y[c_msb]) && (w_sum[c_msb] != w_op_x[c_msb]);
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    mode_d  = mode_q;
    shamt_d = shamt_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          c_d     = C;
          mode_d  = mode;
          shamt_d = shamt;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_ADD1;
        end
      end
      ST_ADD1: begin
        t_d     = w_sum;
        ovf_d   = ovf_q | w_add_ovf;
        state_d = ST_ADD2;
      end
      ST_ADD2: begin
        t_d     = w_sum;
        ovf_d   = ovf_q | w_add_ovf;
        state_d = (shamt_q != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        t_d   = {t_q[WIDTH-2:0], 1'b0};
        ovf_d = ovf_q | (t_q[c_msb] ^ t_q[c_msb-1]);
        if (cnt_q == SHW'(shamt_q - 1'b1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge Clr) begin
    if (!Clr) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      mode_q  <= 1'b0;
      shamt_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      mode_q  <= mode_d;
      shamt_q <= shamt_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = t_q;
  assign ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_arith_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seq_arith_unit : directed self-checking bench for seq_arith_unit
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_seq_arith_unit;

  logic       CLK = 1'b0;
  logic       Clr;
  logic       start;
  logic       mode;
  logic [2:0] shamt;
  logic [7:0] A, B, C;
  logic       busy, done, ovf;
  logic [7:0] result;

  int total = 0;
  int bad   = 0;

  seq_arith_unit #(.WIDTH(8), .SHW(3)) dut (
    .CLK   (CLK),
    .Clr   (Clr),
    .start (start),
    .mode  (mode),
    .shamt (shamt),
    .A     (A),
    .B     (B),
    .C     (C),
    .busy  (busy),
    .done  (done),
    .result(result),
    .ovf   (ovf)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle away from it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // start is raised just after edge 0 and sampled at edge 1; done expected after edge 3+N
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic m, input logic [2:0] n,
                        input logic [7:0] er, input logic eo);
    int cyc;
    start = 1'b1; A = a; B = b; C = c; mode = m; shamt = n;
    tick();
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 3 + int'(n));
    check({tag, "_result"}, result, er);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_busy_in_done"}, busy, 1'b1);
    tick();
    check({tag, "_done_low"}, done, 1'b0);
    check({tag, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin
    int done_cnt;
    int done_edge;
    int prev_edge;
    int npulse;

    Clr = 1'b0; start = 1'b0; mode = 1'b0; shamt = '0; A = '0; B = '0; C = '0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_ovf", ovf, 1'b0);
    tick();
    Clr = 1'b1;
    tick();

    run_op("base_m0", 8'd2, 8'd4, 8'd3, 1'b0, 3'd1, 8'd6, 1'b0);
    run_op("base_m1", 8'd2, 8'd4, 8'd3, 1'b1, 3'd1, 8'd2, 1'b0);
    run_op("n0", 8'd5, 8'd1, 8'd3, 1'b0, 3'd0, 8'd3, 1'b0);
    run_op("n7", 8'd1, 8'd0, 8'd0, 1'b0, 3'd7, 8'h80, 1'b1);
    run_op("add_ovf", 8'd100, 8'd100, 8'd0, 1'b0, 3'd0, 8'hC8, 1'b1);

    tick();
    tick();
    check("idle_hold_result", result, 8'hC8);
    check("idle_hold_ovf", ovf, 1'b1);
    check("idle_hold_busy", busy, 1'b0);

    run_op("ovf_clear", 8'd1, 8'd1, 8'd0, 1'b0, 3'd0, 8'd2, 1'b0);

    // start pulse during SHIFT must be ignored
    start = 1'b1; A = 8'd2; B = 8'd4; C = 8'd3; mode = 1'b0; shamt = 3'd3;
    done_cnt = 0; done_edge = -1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 1) start = 1'b0;
      if (e == 3) begin
        start = 1'b1; A = 8'd9;
      end
      if (e == 4) begin
        start = 1'b0; A = 8'd2;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_edge = e;
        check("busy_start_result", result, 8'd24);
        check("busy_start_busy", busy, 1'b1);
      end
    end
    check("busy_start_pulses", done_cnt, 1);
    check("busy_start_edge", done_edge, 6);
    check("busy_start_idle", busy, 1'b0);

    // asynchronous reset while in ADD2
    start = 1'b1; A = 8'd100; B = 8'd100; C = 8'd5; mode = 1'b0; shamt = 3'd2;
    tick();
    start = 1'b0;
    tick();
    check("pre_rst_result", result, 8'hC8);
    check("pre_rst_ovf", ovf, 1'b1);
    #2;
    Clr = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_result", result, 8'h00);
    check("midrst_ovf", ovf, 1'b0);
    tick();
    Clr = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      check("post_rst_idle_busy", busy, 1'b0);
      check("post_rst_idle_done", done, 1'b0);
    end

    // start held high: done every 5 cycles for N=1
    start = 1'b1; A = 8'd2; B = 8'd4; C = 8'd3; mode = 1'b0; shamt = 3'd1;
    prev_edge = -1; npulse = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (done === 1'b1) begin
        npulse++;
        check("b2b_result", result, 8'd6);
        if (prev_edge < 0) check("b2b_first_edge", e, 4);
        else check("b2b_period", e - prev_edge, 5);
        prev_edge = e;
      end
    end
    check("b2b_pulses", npulse, 4);
    start = 1'b0;
    for (int e = 0; e < 10 && busy === 1'b1; e++) tick();
    check("b2b_drain", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
